// File: rtl/soc_mem_wait_if.sv
// CPU-side request/response bus of the unified instruction/data memory.
// Handshake: master raises valid with addr/wdata/we/wstrb stable; the slave samples them
// on an IDLE rising edge. mem_rdy is a one-cycle pulse completing that request, and
// mem_rdata is meaningful for reads while mem_rdy is high. valid still high in the IDLE
// cycle after the pulse is a new request.
interface soc_mem_wait_if;
  logic        valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  modport master (
    output valid, mem_addr, mem_wdata, mem_we, mem_wstrb,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  valid, mem_addr, mem_wdata, mem_we, mem_wstrb,
    output mem_rdata, mem_rdy
  );
endinterface

// File: rtl/soc_mem_wait.sv
// Unified instruction/data memory with configurable wait states, byte strobes,
// an LED MMIO register and a sticky error flag.
module soc_mem_wait #(
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FF00,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  soc_mem_wait_if.slave        bus,
  output logic [7:0]           led,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [29:0]   BASE_W   = BASE_ADDR[31:2];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rdy_q, rdy_d;
  logic [7:0]      led_q, led_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  // With zero wait states the access commits on the sampling edge, so decode the live bus.
  logic            use_bus;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_we;
  logic [3:0]      acc_wstrb;
  logic [29:0]     off_w;
  logic            in_ram;
  logic            is_io;
  logic            misal;
  logic [DEPTH_LOG2-1:0] idx;
  logic            commit;
  logic            ram_we;

  assign use_bus   = (state_q == S_IDLE);
  assign acc_addr  = use_bus ? bus.mem_addr  : addr_q;
  assign acc_wdata = use_bus ? bus.mem_wdata : wdata_q;
  assign acc_we    = use_bus ? bus.mem_we    : we_q;
  assign acc_wstrb = use_bus ? bus.mem_wstrb : wstrb_q;

  assign off_w  = acc_addr[31:2] - BASE_W;
  assign in_ram = ((off_w >> DEPTH_LOG2) == 30'd0);
  assign idx    = off_w[DEPTH_LOG2-1:0];
  assign is_io  = (acc_addr == IO_ADDR);
  assign misal  = (acc_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          we_d    = bus.mem_we;
          wstrb_d = bus.mem_wstrb;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (is_io) begin
        if (acc_we && acc_wstrb[0]) led_d = acc_wdata[7:0];
        if (!acc_we) rdata_d = {24'h0, led_q};
      end else if (in_ram) begin
        if (misal) err_d = 1'b1;
        if (!acc_we) rdata_d = mem[idx];
      end else begin
        err_d = 1'b1;
        if (!acc_we) rdata_d = 32'hDEAD_BEEF;
      end
    end
    rdy_d = commit;
  end

  // A reset on the commit edge abandons the access, including its RAM write.
  assign ram_we = commit && !sys_rst && !is_io && in_ram && !misal && acc_we;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rdy   = rdy_q;
  assign led           = led_q;
  assign err           = err_q;
  assign busy          = (state_q != S_IDLE);
  assign state_dbg     = state_q;

endmodule
